// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: request opcode and controller state encodings.
package lsu_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_LOAD  = 2'b01,
        OP_STORE = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RESP  = 3'd2,
        S_STORE = 3'd3,
        S_CLEAR = 3'd4
    } state_e;

endpackage

// File: rtl/lsu.sv
// Load/store unit between a CPU request port and a single-port data memory; LOAD response 2 cycles
// after acceptance and held until resp_ready; req_ready only in IDLE, CLEAR sweeps all 2**A entries.
module lsu
    import lsu_pkg::*;
#(
    parameter int W = 8,
    parameter int A = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [1:0]   req_op,
    input  logic [A-1:0] req_addr,
    input  logic [W-1:0] req_wdata,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [W-1:0] resp_rdata,
    output logic         clear_done,
    output logic [A-1:0] mem_addr,
    output logic [W-1:0] mem_wdata,
    output logic         mem_re,
    output logic         mem_we,
    input  logic [W-1:0] mem_rdata
);

    localparam logic [A-1:0] CNT_MAX = '1;

    state_e         state;
    logic [A-1:0]   addr_q;
    logic [W-1:0]   wdata_q;
    logic [A-1:0]   cnt;
    logic [A-1:0]   cnt_nxt;

    assign cnt_nxt = cnt + 1'b1;

    // All outputs are registered: each branch sets the values the next state must present.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt        <= '0;
            resp_rdata <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            clear_done <= 1'b0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            clear_done <= 1'b0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        case (op_e'(req_op))
                            OP_LOAD: begin
                                state     <= S_LOAD;
                                req_ready <= 1'b0;
                                mem_re    <= 1'b1;
                                mem_addr  <= req_addr;
                            end
                            OP_STORE: begin
                                state     <= S_STORE;
                                req_ready <= 1'b0;
                                mem_we    <= 1'b1;
                                mem_addr  <= req_addr;
                                mem_wdata <= req_wdata;
                            end
                            OP_CLEAR: begin
                                state     <= S_CLEAR;
                                req_ready <= 1'b0;
                                cnt       <= '0;
                                mem_we    <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                S_LOAD: begin
                    resp_rdata <= mem_rdata;
                    resp_valid <= 1'b1;
                    state      <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                S_STORE: begin
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                S_CLEAR: begin
                    if (cnt == CNT_MAX) begin
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        // clear_done is raised alongside the write of the last entry
                        cnt        <= cnt_nxt;
                        mem_we     <= 1'b1;
                        mem_addr   <= cnt_nxt;
                        clear_done <= (cnt_nxt == CNT_MAX);
                    end
                end
                default: begin
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: behavioural data memory, reference memory and a load-response scoreboard.
module tb_lsu;
    import lsu_pkg::*;

    localparam int W = 8;
    localparam int A = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [1:0]   req_op = 2'b00;
    logic [A-1:0] req_addr = '0;
    logic [W-1:0] req_wdata = '0;
    logic         resp_valid;
    logic         resp_ready = 1'b1;
    logic [W-1:0] resp_rdata;
    logic         clear_done;
    logic [A-1:0] mem_addr;
    logic [W-1:0] mem_wdata;
    logic         mem_re;
    logic         mem_we;
    logic [W-1:0] mem_rdata;

    logic [W-1:0] dmem    [2**A];
    logic [W-1:0] ref_mem [2**A];
    logic [W-1:0] sb[$];

    int  vectors = 0;
    int  miscompares = 0;
    bit  rand_rr = 1'b0;
    bit  model_clear = 1'b1;

    always #5 clk = ~clk;

    lsu #(.W(W), .A(A)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .clear_done (clear_done),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata)
    );

    // Data memory with combinational read, unaffected by lsu reset.
    assign mem_rdata = dmem[mem_addr];
    always @(posedge clk) if (mem_we) dmem[mem_addr] <= mem_wdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Response scoreboard and structural invariants, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            chk("re_we_exclusive", {31'd0, mem_re & mem_we}, 32'd0);
            chk("ready_only_idle", {31'd0, req_ready}, {31'd0, dut.state == S_IDLE});
            chk("valid_only_resp", {31'd0, resp_valid}, {31'd0, dut.state == S_RESP});
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) chk("resp_unexpected", 32'd1, 32'd0);
                else chk("resp_rdata", {24'd0, resp_rdata}, {24'd0, sb.pop_front()});
            end
        end
    end

    // Called at a negedge with req_ready=1: present one request and update the reference model.
    task automatic drive_now(input logic [1:0] op, input logic [A-1:0] addr, input logic [W-1:0] data);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = data;
        case (op)
            2'b01: sb.push_back(ref_mem[addr]);
            2'b10: ref_mem[addr] = data;
            2'b11: if (model_clear) for (int i = 0; i < 2**A; i++) ref_mem[i] = '0;
            default: ;
        endcase
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 2'b00;
    endtask

    task automatic issue(input logic [1:0] op, input logic [A-1:0] addr, input logic [W-1:0] data,
                         output int waited);
        waited = 0;
        @(negedge clk);
        while (!req_ready && waited < 1000) begin
            @(posedge clk);
            #1;
            if (rand_rr) resp_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            waited++;
        end
        if (waited >= 1000) chk("req_ready_timeout", 32'd0, 32'd1);
        drive_now(op, addr, data);
    endtask

    initial begin
        int w;
        int we_cnt;
        int done_cnt;
        int done_addr;
        int r;

        for (int i = 0; i < 2**A; i++) begin
            dmem[i]    = '0;
            ref_mem[i] = '0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_clear_done", {31'd0, clear_done}, 32'd0);
        chk("rst_mem_re", {31'd0, mem_re}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        chk("rst_resp_rdata", {24'd0, resp_rdata}, 32'd0);

        // STORE then LOAD with cycle-exact checks
        issue(2'b10, 8'h10, 8'hA5, w);
        @(negedge clk);
        chk("st_mem_we", {31'd0, mem_we}, 32'd1);
        chk("st_mem_re", {31'd0, mem_re}, 32'd0);
        chk("st_mem_addr", {24'd0, mem_addr}, 32'h10);
        chk("st_mem_wdata", {24'd0, mem_wdata}, 32'hA5);
        @(negedge clk);
        chk("st_back_idle", {31'd0, req_ready}, 32'd1);
        chk("st_no_resp", {31'd0, resp_valid}, 32'd0);
        chk("st_we_off", {31'd0, mem_we}, 32'd0);
        issue(2'b01, 8'h10, 8'h00, w);
        @(negedge clk);
        chk("ld_mem_re", {31'd0, mem_re}, 32'd1);
        chk("ld_mem_addr", {24'd0, mem_addr}, 32'h10);
        chk("ld_n1_no_valid", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        chk("ld_n2_valid", {31'd0, resp_valid}, 32'd1);
        chk("ld_n2_rdata", {24'd0, resp_rdata}, 32'hA5);

        // LOAD held under backpressure
        issue(2'b10, 8'h21, 8'h5A, w);
        @(posedge clk);
        #1 resp_ready = 1'b0;
        issue(2'b01, 8'h21, 8'h00, w);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", {31'd0, resp_valid}, 32'd1);
            chk("hold_rdata", {24'd0, resp_rdata}, 32'h5A);
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 resp_ready = 1'b1;
        @(negedge clk);
        chk("hs_req_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("post_hs_ready", {31'd0, req_ready}, 32'd1);
        chk("post_hs_valid", {31'd0, resp_valid}, 32'd0);

        // Full CLEAR sweep
        issue(2'b10, 8'h00, 8'h3C, w);
        issue(2'b10, 8'hFF, 8'h3C, w);
        issue(2'b11, 8'h00, 8'h00, w);
        we_cnt = 0; done_cnt = 0; done_addr = -1;
        repeat (300) begin
            @(negedge clk);
            if (mem_we) we_cnt++;
            if (clear_done) begin
                done_cnt++;
                done_addr = int'(mem_addr);
            end
        end
        chk("clr_we_cycles", we_cnt, 256);
        chk("clr_done_pulses", done_cnt, 1);
        chk("clr_done_addr", done_addr, 32'hFF);
        issue(2'b01, 8'h00, 8'h00, w);
        issue(2'b01, 8'hFF, 8'h00, w);

        // CLEAR aborted by reset on its 100th cycle
        issue(2'b10, 8'hFF, 8'h77, w);
        issue(2'b10, 8'h64, 8'h55, w);
        issue(2'b10, 8'h00, 8'h11, w);
        model_clear = 1'b0;
        issue(2'b11, 8'h00, 8'h00, w);
        model_clear = 1'b1;
        done_cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (clear_done) done_cnt++;
        end
        chk("abort_cycle_addr", {24'd0, mem_addr}, 32'd99);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 100; i++) ref_mem[i] = '0;
        @(negedge clk);
        chk("abort_idle", {31'd0, req_ready}, 32'd1);
        chk("abort_we_off", {31'd0, mem_we}, 32'd0);
        chk("abort_rdata_rst", {24'd0, resp_rdata}, 32'd0);
        repeat (5) begin
            if (clear_done) done_cnt++;
            @(negedge clk);
        end
        chk("abort_no_done", done_cnt, 0);
        issue(2'b01, 8'hFF, 8'h00, w);
        issue(2'b01, 8'h64, 8'h00, w);
        issue(2'b01, 8'h00, 8'h00, w);

        // NOP, second NOP carrying stale-looking data, then back-to-back STORE
        issue(2'b00, 8'h33, 8'h44, w);
        @(negedge clk);
        chk("nop_mem_re", {31'd0, mem_re}, 32'd0);
        chk("nop_mem_we", {31'd0, mem_we}, 32'd0);
        chk("nop_mem_addr", {24'd0, mem_addr}, 32'd0);
        chk("nop_ready", {31'd0, req_ready}, 32'd1);
        drive_now(2'b00, 8'hEE, 8'hDD);
        @(negedge clk);
        chk("nop2_mem_re", {31'd0, mem_re}, 32'd0);
        chk("nop2_mem_we", {31'd0, mem_we}, 32'd0);
        chk("nop2_ready", {31'd0, req_ready}, 32'd1);
        drive_now(2'b10, 8'h42, 8'hC3);
        @(negedge clk);
        chk("b2b_store_we", {31'd0, mem_we}, 32'd1);
        chk("b2b_store_addr", {24'd0, mem_addr}, 32'h42);
        issue(2'b01, 8'h42, 8'h00, w);

        // Random request stream with random response backpressure
        rand_rr = 1'b1;
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 99);
            if (r < 2)       issue(2'b11, 8'h00, 8'h00, w);
            else if (r < 40) issue(2'b01, 8'($urandom_range(0, 15)), 8'h00, w);
            else if (r < 80) issue(2'b10, 8'($urandom_range(0, 15)), 8'($urandom), w);
            else             issue(2'b00, 8'($urandom), 8'($urandom), w);
        end
        rand_rr = 1'b0;
        @(posedge clk);
        #1 resp_ready = 1'b1;
        w = 0;
        while (sb.size() != 0 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        chk("drain_scoreboard", sb.size(), 0);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
